// File: rtl/core_pkg.sv
// Shared types and defaults for the core pipeline control blocks.
package core_pkg;

  localparam int unsigned REG_ADDR_W       = 5;
  localparam int unsigned FLUSH_CYCLES_DEF = 1;
  localparam int unsigned MEM_TIMEOUT_DEF  = 255;
  localparam int unsigned FLUSH_CNT_W      = 4;
  localparam int unsigned WAIT_CNT_W       = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_lu_detect.sv
// Load-use comparator: the load in EX targets a register that the instruction in ID reads.
module hazard_lu_detect
  import core_pkg::*;
(
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  output logic                  lu_o
);

  // x0 is hardwired to zero, so a load into it never creates a dependency.
  always_comb begin
    lu_o = ex_memread_i && (ex_rd_i != '0) &&
           ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, data-memory freeze with timeout.
// Define HAZARD_PERF_CNT_EN to add the stall_cnt_o / flush_cnt_o performance counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int unsigned MEM_TIMEOUT  = MEM_TIMEOUT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  branch_taken_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ack_i,
  output logic                  pc_write_o,
  output logic                  if_id_stall_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_bubble_o,
  output logic                  freeze_o,
  output logic                  mem_err_o,
  output hz_state_e             state_dbg_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0]  WAIT_LIMIT = WAIT_CNT_W'(MEM_TIMEOUT);

  hz_state_e              state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic                   mem_err_q, mem_err_d;

  logic lu;
  logic mem_stall;
  logic run_eval;
  logic mem_masked;

  hazard_lu_detect u_lu_detect (
    .ex_memread_i (ex_memread_i),
    .ex_rd_i      (ex_rd_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .lu_o         (lu)
  );

  // Memory handshake: mem_req_i marks an outstanding access that completes in the
  // cycle mem_ack_i is high; req without ack means the whole pipeline must hold.
  assign mem_stall = mem_req_i && !mem_ack_i;

  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    mem_err_d      = mem_err_q;
    pc_write_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    freeze_o       = 1'b0;
    run_eval       = 1'b0;
    mem_masked     = 1'b0;

    if (!rst_i || !start_i) begin
      if_id_flush_o = 1'b1;
      state_d       = RUN;
      flush_cnt_d   = '0;
      wait_cnt_d    = '0;
    end else begin
      unique case (state_q)
        RUN: run_eval = 1'b1;
        FLUSH: begin
          if (mem_stall) begin
            freeze_o      = 1'b1;
            if_id_stall_o = 1'b1;
            state_d       = MEM_WAIT;
            wait_cnt_d    = WAIT_CNT_W'(1);
          end else begin
            if_id_flush_o = 1'b1;
            pc_write_o    = 1'b1;
            if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
              state_d     = RUN;
              flush_cnt_d = '0;
            end else begin
              flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
            end
          end
        end
        MEM_WAIT: begin
          if (mem_ack_i) begin
            run_eval = 1'b1;
          end else if (wait_cnt_q == WAIT_LIMIT) begin
            // Timeout releases the pipeline this cycle; the pending request is ignored once.
            mem_err_d  = 1'b1;
            run_eval   = 1'b1;
            mem_masked = 1'b1;
          end else begin
            freeze_o      = 1'b1;
            if_id_stall_o = 1'b1;
            wait_cnt_d    = wait_cnt_q + WAIT_CNT_W'(1);
          end
        end
        default: state_d = RUN;
      endcase

      if (run_eval) begin
        state_d     = RUN;
        flush_cnt_d = '0;
        wait_cnt_d  = '0;
        if (mem_stall && !mem_masked) begin
          freeze_o      = 1'b1;
          if_id_stall_o = 1'b1;
          state_d       = MEM_WAIT;
          wait_cnt_d    = WAIT_CNT_W'(1);
        end else if (lu) begin
          // A branch in ID is held along with it and gets re-evaluated next cycle.
          if_id_stall_o  = 1'b1;
          id_ex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
          if_id_flush_o = 1'b1;
          pc_write_o    = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end
        end else begin
          pc_write_o = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign mem_err_o   = mem_err_q;
  assign state_dbg_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fl_cnt_q, fl_cnt_d;

  // Both counters saturate instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fl_cnt_d    = fl_cnt_q;
    if (if_id_stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (if_id_flush_o && start_i && (fl_cnt_q != '1)) begin
      fl_cnt_d = fl_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      fl_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fl_cnt_q    <= fl_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = fl_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_hazard_ctrl;
  import core_pkg::*;

  localparam int unsigned FC = 2;
  localparam int unsigned MT = 8;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic       ex_memread_i;
  logic [4:0] ex_rd_i;
  logic       branch_taken_i;
  logic       mem_req_i;
  logic       mem_ack_i;
  logic       pc_write_o;
  logic       if_id_stall_o;
  logic       if_id_flush_o;
  logic       id_ex_bubble_o;
  logic       freeze_o;
  logic       mem_err_o;
  hz_state_e  state_dbg_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: remaining flush cycles, freeze cycles so far, sticky error.
  int m_flush_left;
  int m_frozen;
  bit m_err;

  logic [5:0] obs_vec;
  logic [5:0] exp_vec;
  // Order: {pc_write, stall, flush, bubble, freeze, mem_err}
  assign obs_vec = {pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o, freeze_o, mem_err_o};

  hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .ex_memread_i   (ex_memread_i),
    .ex_rd_i        (ex_rd_i),
    .branch_taken_i (branch_taken_i),
    .mem_req_i      (mem_req_i),
    .mem_ack_i      (mem_ack_i),
    .pc_write_o     (pc_write_o),
    .if_id_stall_o  (if_id_stall_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_bubble_o (id_ex_bubble_o),
    .freeze_o       (freeze_o),
    .mem_err_o      (mem_err_o),
    .state_dbg_o    (state_dbg_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
`endif
  );

  // Clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input logic st, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic mr, input logic [4:0] rd, input logic br,
                        input logic req, input logic ack);
    start_i        = st;
    id_rs1_i       = rs1;
    id_rs2_i       = rs2;
    ex_memread_i   = mr;
    ex_rd_i        = rd;
    branch_taken_i = br;
    mem_req_i      = req;
    mem_ack_i      = ack;
  endtask

  task automatic model_reset();
    m_flush_left = 0;
    m_frozen     = 0;
    m_err        = 1'b0;
  endtask

  // Applies the hazard rules to the current inputs; returns this cycle's outputs, advances the model.
  function automatic logic [5:0] model_step();
    logic pc, st, fl, bb, fz, e;
    bit   lu, ms, run, ign;
    pc = 0; st = 0; fl = 0; bb = 0; fz = 0;
    run = 0; ign = 0;
    e  = m_err;
    lu = ex_memread_i && (ex_rd_i != 0) && (ex_rd_i == id_rs1_i || ex_rd_i == id_rs2_i);
    ms = mem_req_i && !mem_ack_i;
    if (!rst_i || !start_i) begin
      fl = 1;
      m_flush_left = 0;
      m_frozen = 0;
    end else if (m_frozen > 0) begin
      if (mem_ack_i) begin
        m_frozen = 0;
        run = 1;
      end else if (m_frozen == int'(MT)) begin
        m_frozen = 0;
        m_err = 1'b1;
        run = 1;
        ign = 1;
      end else begin
        fz = 1; st = 1;
        m_frozen++;
      end
    end else if (m_flush_left > 0) begin
      if (ms) begin
        fz = 1; st = 1;
        m_frozen = 1;
        m_flush_left = 0;
      end else begin
        fl = 1; pc = 1;
        m_flush_left--;
      end
    end else begin
      run = 1;
    end
    if (run) begin
      if (ms && !ign) begin
        fz = 1; st = 1;
        m_frozen = 1;
      end else if (lu) begin
        st = 1; bb = 1;
      end else if (branch_taken_i) begin
        fl = 1; pc = 1;
        m_flush_left = int'(FC) - 1;
      end else begin
        pc = 1;
      end
    end
    return {pc, st, fl, bb, fz, e};
  endfunction

  task automatic test_reset();
    rst_i = 1'b0;
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    n_vec++;
    if (obs_vec !== 6'b001000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want %b", obs_vec, 6'b001000);
    end
    n_vec++;
    if (state_dbg_o !== RUN) begin
      n_err++;
      $display("FAIL reset_state: got %0d want %0d", state_dbg_o, RUN);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #3;
    exp_vec = model_step();
    n_vec++;
    if (obs_vec !== 6'b100000 || obs_vec !== exp_vec) begin
      n_err++;
      $display("FAIL reset_release: got %b want %b", obs_vec, 6'b100000);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_load_use();
    logic [5:0] want [4] = '{6'b010100, 6'b100000, 6'b100000, 6'b010100};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       set_in(1, 5'd0, 5'd5, 1, 5'd5, 0, 0, 0);
        1:       set_in(1, 5'd3, 5'd4, 1, 5'd5, 0, 0, 0);
        2:       set_in(1, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0);
        default: set_in(1, 5'd5, 5'd9, 1, 5'd5, 0, 0, 0);
      endcase
      #3;
      exp_vec = model_step();
      n_vec++;
      if (obs_vec !== want[i] || obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL load_use[%0d]: got %b want %b model %b", i, obs_vec, want[i], exp_vec);
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_branch();
    logic [5:0] want [4] = '{6'b101000, 6'b101000, 6'b100000, 6'b100000};
    for (int i = 0; i < 4; i++) begin
      set_in(1, 5'd1, 5'd2, 0, 5'd0, (i == 0), 0, 0);
      #3;
      exp_vec = model_step();
      n_vec++;
      if (obs_vec !== want[i] || obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL branch[%0d]: got %b want %b model %b", i, obs_vec, want[i], exp_vec);
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_branch_lu();
    logic [5:0] want [4] = '{6'b010100, 6'b101000, 6'b101000, 6'b100000};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       set_in(1, 5'd7, 5'd2, 1, 5'd7, 1, 0, 0);
        1:       set_in(1, 5'd7, 5'd2, 0, 5'd0, 1, 0, 0);
        default: set_in(1, 5'd7, 5'd2, 0, 5'd0, 0, 0, 0);
      endcase
      #3;
      exp_vec = model_step();
      n_vec++;
      if (obs_vec !== want[i] || obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL branch_lu[%0d]: got %b want %b model %b", i, obs_vec, want[i], exp_vec);
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_mem_wait();
    logic [5:0] want [8] = '{6'b010010, 6'b010010, 6'b010010, 6'b010010,
                             6'b100000, 6'b100000, 6'b100000, 6'b100000};
    for (int i = 0; i < 8; i++) begin
      // cycles 0-3 wait, 4 ack, 6 single-cycle access
      set_in(1, 5'd1, 5'd2, 0, 5'd0, 0, (i <= 4 || i == 6), (i == 4 || i == 6));
      #3;
      exp_vec = model_step();
      n_vec++;
      if (obs_vec !== want[i] || obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL mem_wait[%0d]: got %b want %b model %b", i, obs_vec, want[i], exp_vec);
      end
      @(posedge clk_i); #1;
    end
    #3;
    n_vec++;
    if (state_dbg_o !== RUN) begin
      n_err++;
      $display("FAIL single_access_state: got %0d want %0d", state_dbg_o, RUN);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_flush_freeze();
    logic [5:0] want [5] = '{6'b101000, 6'b010010, 6'b010010, 6'b100000, 6'b100000};
    for (int i = 0; i < 5; i++) begin
      set_in(1, 5'd1, 5'd2, 0, 5'd0, (i == 0), (i >= 1 && i <= 3), (i == 3));
      #3;
      exp_vec = model_step();
      n_vec++;
      if (obs_vec !== want[i] || obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL flush_freeze[%0d]: got %b want %b model %b", i, obs_vec, want[i], exp_vec);
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_timeout();
    int freeze_cycles = 0;
    for (int i = 0; i < 13; i++) begin
      set_in((i != 11), 5'd1, 5'd2, 0, 5'd0, 0, (i <= 8), 0);
      #3;
      exp_vec = model_step();
      if (freeze_o === 1'b1) freeze_cycles++;
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL timeout[%0d]: got %b want %b", i, obs_vec, exp_vec);
      end
      @(posedge clk_i); #1;
    end
    n_vec++;
    if (freeze_cycles != int'(MT)) begin
      n_err++;
      $display("FAIL timeout_len: got %0d freeze cycles want %0d", freeze_cycles, MT);
    end
    n_vec++;
    if (mem_err_o !== 1'b1) begin
      n_err++;
      $display("FAIL mem_err_sticky: got %b want 1", mem_err_o);
    end
    rst_i = 1'b0;
    model_reset();
    #2;
    n_vec++;
    if (obs_vec !== 6'b001000) begin
      n_err++;
      $display("FAIL mem_err_reset: got %b want %b", obs_vec, 6'b001000);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    set_in(1, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0);
    #3;
    exp_vec = model_step();
    n_vec++;
    if (obs_vec !== 6'b100000 || obs_vec !== exp_vec) begin
      n_err++;
      $display("FAIL after_err_reset: got %b want %b", obs_vec, 6'b100000);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid_flush();
    set_in(1, 5'd1, 5'd2, 0, 5'd0, 1, 0, 0);
    #3;
    exp_vec = model_step();
    @(posedge clk_i); #1;
    branch_taken_i = 1'b0;
    #1;
    n_vec++;
    if (obs_vec !== 6'b101000 || state_dbg_o !== FLUSH) begin
      n_err++;
      $display("FAIL mid_flush_pre: got %b/%0d want %b/%0d", obs_vec, state_dbg_o, 6'b101000, FLUSH);
    end
    rst_i = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (obs_vec !== 6'b001000 || state_dbg_o !== RUN) begin
      n_err++;
      $display("FAIL mid_flush_reset: got %b/%0d want %b/%0d", obs_vec, state_dbg_o, 6'b001000, RUN);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #3;
    exp_vec = model_step();
    n_vec++;
    if (obs_vec !== 6'b100000 || obs_vec !== exp_vec) begin
      n_err++;
      $display("FAIL mid_flush_release: got %b want %b", obs_vec, 6'b100000);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      set_in(($urandom_range(0, 29) != 0),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
             ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
      #3;
      exp_vec = model_step();
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL random[%0d]: got %b want %b", i, obs_vec, exp_vec);
      end
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_branch_lu();
    test_mem_wait();
    test_flush_freeze();
    test_timeout();
    test_reset_mid_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage core. It drives the stall and flush inputs of the IF/ID pipeline register, the PC write-enable and the ID/EX bubble. It resolves three hazard classes:
- load-use data hazards (one-cycle stall),
- taken branches (multi-cycle IF/ID flush),
- multi-cycle data-memory accesses (whole-pipeline freeze, with a timeout).

## Interface
Parameters:
- FLUSH_CYCLES, 1, number of cycles if_id_flush_o is held after a taken branch (1..15)
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before forced release (1..65535)

Ports:
- clk_i  in  1  clock, all state updates on posedge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  core run enable; low holds the core idle
- id_rs1_i  in  5  rs1 of the instruction in ID
- id_rs2_i  in  5  rs2 of the instruction in ID
- ex_memread_i  in  1  instruction in EX is a load
- ex_rd_i  in  5  destination register of the instruction in EX
- branch_taken_i  in  1  branch resolved taken in ID this cycle
- mem_req_i  in  1  MEM stage has an outstanding data-memory access
- mem_ack_i  in  1  data memory completes the access this cycle
- pc_write_o  out  1  PC register update enable
- if_id_stall_o  out  1  IF/ID hold
- if_id_flush_o  out  1  IF/ID load zero (nop)
- id_ex_bubble_o  out  1  ID/EX loads zeroed control
- freeze_o  out  1  ID/EX, EX/MEM, MEM/WB hold
- mem_err_o  out  1  sticky MEM_WAIT timeout flag

## Operation
- FSM states: RUN, FLUSH, MEM_WAIT. Reset state is RUN.
- Outputs are Mealy: a function of state and current inputs. Only the state, the counters and mem_err_o are registered.
- Load-use hazard (lu) is true when all hold: ex_memread_i, ex_rd_i != 0, and ex_rd_i equals id_rs1_i or id_rs2_i.
- Priority, highest first: start_i low > freeze > lu > flush.
- start_i low: pc_write_o=0, if_id_flush_o=1, all other outputs 0. FSM goes to RUN and counters clear.
- RUN:
  - mem_req_i && !mem_ack_i → freeze_o=1, if_id_stall_o=1, pc_write_o=0; go to MEM_WAIT; wait counter loads 1.
  - else lu → if_id_stall_o=1, pc_write_o=0, id_ex_bubble_o=1; stay in RUN. branch_taken_i is ignored in this cycle and is re-evaluated next cycle because ID is held.
  - else branch_taken_i → if_id_flush_o=1, pc_write_o=1. If FLUSH_CYCLES>1, go to FLUSH and load the flush counter with FLUSH_CYCLES-1.
  - else pc_write_o=1, all other outputs 0.
- FLUSH: if_id_flush_o=1, pc_write_o=1. The counter decrements each cycle; at 1, return to RUN. A memory freeze overrides FLUSH; the counter holds and the FSM goes to MEM_WAIT. Once the freeze ends, the FSM returns to RUN and the remaining flush count is dropped. lu is ignored in FLUSH because ID contains a nop.
- MEM_WAIT: freeze_o=1, if_id_stall_o=1, pc_write_o=0, and the wait counter increments.
  - mem_ack_i → outputs take RUN values for this cycle; go to RUN.
  - counter == MEM_TIMEOUT without ack → set mem_err_o, release the freeze this cycle, go to RUN.
- mem_err_o clears only on reset.

## Timing
- Reset (rst_i low, asynchronous): state=RUN, counters=0, mem_err_o=0. While reset is held, outputs follow the start_i-low pattern (pc_write_o=0, if_id_flush_o=1).
- Reset asserted mid-FLUSH or mid-MEM_WAIT aborts the operation immediately, with no further flush or freeze.
- Latency:
  - load-use stall is exactly 1 cycle per hazard;
  - flush lasts FLUSH_CYCLES cycles;
  - a freeze lasts from the first cycle of mem_req_i && !mem_ack_i through the cycle before the ack.
- A single-cycle access (mem_req_i and mem_ack_i in the same cycle) causes no freeze and no state change.
- The wait counter is 16 bits and never wraps. Timeout fires on equality with MEM_TIMEOUT.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o counts cycles with if_id_stall_o=1.
  - flush_cnt_o counts cycles with if_id_flush_o=1 while start_i is high.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- HAZARD_PERF_CNT_EN undefined: no counters and no ports; behaviour is otherwise identical.

## Structure
- Shared package core_pkg holds:
  - the state enum (RUN, FLUSH, MEM_WAIT);
  - REG_ADDR_W=5;
  - defaults for FLUSH_CYCLES and MEM_TIMEOUT.
- One sub-module: hazard_lu_detect, a combinational load-use comparator instantiated by hazard_ctrl.
- The FSM and counters live in hazard_ctrl.

## Test plan
- Load-use: ex_memread_i=1, ex_rd_i=5, id_rs2_i=5 for one cycle → if_id_stall_o=1, id_ex_bubble_o=1, pc_write_o=0 for exactly that cycle. With ex_rd_i=0 → no stall.
- Branch with FLUSH_CYCLES=2: branch_taken_i pulses for 1 cycle → if_id_flush_o=1 for 2 consecutive cycles, pc_write_o=1 in both.
- Branch and load-use in the same cycle → stall only (no flush). The flush follows next cycle once the hazard clears.
- Memory wait: mem_req_i=1 with ack after 4 cycles → freeze_o=1 for 4 cycles, 0 in the ack cycle, mem_err_o=0.
- Timeout with MEM_TIMEOUT=8 and no ack → freeze_o released after 8 MEM_WAIT cycles, mem_err_o=1 and stays set until rst_i pulses low.
- Reset mid-FLUSH: assert rst_i low during the second flush cycle → state RUN and counters 0 immediately. After reset release with start_i=1 → pc_write_o=1, if_id_flush_o=0.
